// File: rtl/mips_mc_sequencer.sv
// Multicycle control sequencer for the mips_32 datapath: FETCH/DECODE/EXEC/MEM/WB with a MOC handshake.
// Optional MOC timeout / bus error is compiled in with `define MIPS_MOC_TIMEOUT_EN.
module mips_mc_sequencer #(
  parameter int MOC_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zFlag,
  input  logic       MOC,
  output logic       pc_load,
  output logic       ir_load,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src,
  output logic [4:0] alu_fnc,
  output logic       RAMEnable,
  output logic       RW,
  output logic       mem_to_reg,
  output logic       jump,
  output logic       branch,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state_dbg
);

  // Handshake: RAMEnable/RW are held stable until a cycle with MOC=1 in FETCH or MEM;
  // that cycle completes the access and MOC in any other state is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LW   = 3'd1,
    C_SW   = 3'd2,
    C_BEQ  = 3'd3,
    C_J    = 3'd4,
    C_ADDI = 3'd5,
    C_BAD  = 3'd6
  } cls_e;

  localparam logic [4:0]       FNC_ADD   = 5'd0;
  localparam logic [4:0]       FNC_SUB   = 5'd1;
  localparam logic [4:0]       FNC_FUNCT = 5'd31;
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(MOC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout;
  logic             unused_inputs;

  // funct is consumed by the ALU control unit; zFlag is qualified with branch in the datapath.
  assign unused_inputs = ^{funct, zFlag};

  always_comb begin
    unique case (opcode)
      6'b000000: dec_cls = C_R;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b000010: dec_cls = C_J;
      6'b001000: dec_cls = C_ADDI;
      default:   dec_cls = C_BAD;
    endcase
  end

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MOC;

  // Counter is zero whenever not waiting, so it is clear on every entry to FETCH/MEM.
  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_ONE;
    end
  end

`ifdef MIPS_MOC_TIMEOUT_EN
  logic bus_error_q;

  assign timeout = waiting && (cnt_q == TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error_q <= 1'b0;
    end else if (timeout) begin
      bus_error_q <= 1'b1;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    illegal_d  = illegal_q;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_fnc    = FNC_ADD;
    RAMEnable  = 1'b0;
    RW         = 1'b0;
    mem_to_reg = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        RAMEnable = 1'b1;
        RW        = 1'b1;
        if (MOC) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_BAD) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_R: begin
            alu_fnc = FNC_FUNCT;
            state_d = S_WB;
          end
          C_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_fnc = FNC_SUB;
            branch  = 1'b1;
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
          C_J: begin
            jump    = 1'b1;
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        RAMEnable = 1'b1;
        RW        = (cls_q == C_LW);
        if (MOC) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_R);
        mem_to_reg = (cls_q == C_LW);
        pc_load    = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule
